// File: rtl/pll_lock_sequencer_if.sv
// rtl/pll_lock_sequencer_if.sv - PLL lock sequencer control/status signal bundle
interface pll_lock_sequencer_if;
  logic       locked;
  logic       soft_reset_req;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic [7:0] timeout_cnt;
  logic [7:0] relock_cnt;

  // Environment side: owns the PLL lock pin and the restart request
  modport master (
    output locked, soft_reset_req,
    input  pll_rst, sys_reset, ready, timeout_cnt, relock_cnt
  );

  // Sequencer side
  modport slave (
    input  locked, soft_reset_req,
    output pll_rst, sys_reset, ready, timeout_cnt, relock_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock qualification sequencer with timeout and relock counters
module pll_lock_sequencer #(
  parameter int unsigned RST_PULSE     = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1048576,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned CNT_W         = 24
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  pll_lock_sequencer_if.slave   bus
);

  // One-hot encoding so every output is a direct flop bit
  typedef enum logic [3:0] {
    PLL_RST   = 4'b0001,
    WAIT_LOCK = 4'b0010,
    STABLE    = 4'b0100,
    RUN       = 4'b1000
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       timeout_cnt_q, timeout_cnt_d;
  logic [7:0]       relock_cnt_q, relock_cnt_d;
  logic             sync1_q, sync2_q;
  logic             locked_s;

  assign locked_s = sync2_q;

  // Two-flop synchroniser for the asynchronous PLL lock pin
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.locked;
      sync2_q <= sync1_q;
    end
  end

  // State, shared cycle counter and status counters
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PLL_RST;
      cnt_q         <= '0;
      timeout_cnt_q <= '0;
      relock_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      relock_cnt_q  <= relock_cnt_d;
    end
  end

  // Next state: soft restart beats lock loss, which beats counter expiry
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    timeout_cnt_d = timeout_cnt_q;
    relock_cnt_d  = relock_cnt_q;

    if (bus.soft_reset_req) begin
      state_d = PLL_RST;
    end else begin
      unique case (state_q)
        PLL_RST: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = PLL_RST;
            if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            if (relock_cnt_q != 8'hFF) relock_cnt_d = relock_cnt_q + 8'd1;
          end
        end
        default: state_d = PLL_RST;
      endcase
    end

    // Counter restarts on every transition, on every soft request, and idles at 0 in RUN
    if (bus.soft_reset_req || (state_d != state_q) || (state_q == RUN)) begin
      cnt_d = '0;
    end
  end

  assign bus.pll_rst     = state_q[0];
  assign bus.ready       = state_q[3];
  assign bus.sys_reset   = ~state_q[3];
  assign bus.timeout_cnt = timeout_cnt_q;
  assign bus.relock_cnt  = relock_cnt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed scoreboard bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

  localparam int RST_PULSE     = 4;
  localparam int LOCK_TIMEOUT  = 64;
  localparam int STABLE_CYCLES = 16;
  localparam int BUDGET        = 200;

  logic refclk = 1'b0;
  logic rst_n;

  always #10 refclk = ~refclk;

  pll_lock_sequencer_if bus_if ();

  pll_lock_sequencer #(
    .RST_PULSE     (RST_PULSE),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (8)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus_if.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%0d expected=queued_entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, $signed(obs), $signed(e.exp));
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    push({pfx, "_pll_rst"}, 1);     pop_check(32'(bus_if.pll_rst));
    push({pfx, "_sys_reset"}, 1);   pop_check(32'(bus_if.sys_reset));
    push({pfx, "_ready"}, 0);       pop_check(32'(bus_if.ready));
    push({pfx, "_timeout_cnt"}, 0); pop_check(32'(bus_if.timeout_cnt));
    push({pfx, "_relock_cnt"}, 0);  pop_check(32'(bus_if.relock_cnt));
  endtask

  task automatic edges_until_ready(output int n);
    n = 0;
    while (bus_if.ready !== 1'b1) begin
      if (n >= BUDGET) begin
        n = -1;
        return;
      end
      step(1);
      n++;
    end
  endtask

  task automatic edges_until_sys_reset(input int start, output int n);
    n = start;
    while (bus_if.sys_reset !== 1'b1) begin
      if (n >= BUDGET) begin
        n = -1;
        return;
      end
      step(1);
      n++;
    end
  endtask

  task automatic pll_rst_period(output int n);
    int k;
    n = 0;
    k = 0;
    while (bus_if.pll_rst === 1'b1) begin
      if (k >= BUDGET) begin
        n = -1;
        return;
      end
      step(1);
      k++;
    end
    n = k;
    k = 0;
    while (bus_if.pll_rst === 1'b0) begin
      if (k >= BUDGET) begin
        n = -1;
        return;
      end
      step(1);
      k++;
    end
    n = n + k;
  endtask

  initial begin
    int n;
    int m;
    int bad;

    rst_n                 = 1'b0;
    bus_if.locked         = 1'b0;
    bus_if.soft_reset_req = 1'b0;
    step(3);
    check_reset_outputs("reset");

    // Scenario 1: release reset with no lock; PLL reset pulse width
    rst_n = 1'b1;
    bad   = 0;
    n     = 0;
    while (bus_if.pll_rst === 1'b1 && n < BUDGET) begin
      if (bus_if.sys_reset !== 1'b1 || bus_if.ready !== 1'b0) bad++;
      step(1);
      n++;
    end
    push("t1_pll_rst_width", RST_PULSE); pop_check(32'(n));
    push("t1_core_held", 0);             pop_check(32'(bad));

    // Scenario 2: lock at cycle 10 after release; latency to ready
    step(10 - RST_PULSE);
    bus_if.locked = 1'b1;
    bad = 0;
    n   = 0;
    while (bus_if.ready !== 1'b1 && n < BUDGET) begin
      if (bus_if.pll_rst !== 1'b0) bad++;
      step(1);
      n++;
    end
    push("t2_ready_latency", 2 + STABLE_CYCLES + 1); pop_check(32'(n));
    push("t2_pll_rst_low", 0);                       pop_check(32'(bad));
    push("t2_sys_reset", 0);                         pop_check(32'(bus_if.sys_reset));

    // Scenario 4: one-cycle lock drop in RUN
    bus_if.locked = 1'b0;
    step(1);
    bus_if.locked = 1'b1;
    edges_until_sys_reset(1, n);
    push("t4_drop_to_sys_reset", 3);          pop_check(32'(n));
    push("t4_ready_low", 0);                  pop_check(32'(bus_if.ready));
    push("t4_relock_cnt", 1);                 pop_check(32'(bus_if.relock_cnt));
    edges_until_ready(n);
    push("t4_relock_latency", STABLE_CYCLES + 1); pop_check(32'(n));

    // Scenario 5: second RUN drop, then a lock glitch at counter=10 in STABLE
    bus_if.locked = 1'b0;
    step(1);
    bus_if.locked = 1'b1;
    edges_until_sys_reset(1, n);
    push("t5_drop_to_sys_reset", 3); pop_check(32'(n));
    step(9);
    bus_if.locked = 1'b0;
    step(1);
    bus_if.locked = 1'b1;
    edges_until_ready(m);
    n = (m < 0) ? -1 : m + 1;
    push("t5_stable_restart_latency", 3 + 1 + STABLE_CYCLES); pop_check(32'(n));
    push("t5_relock_cnt", 2);  pop_check(32'(bus_if.relock_cnt));
    push("t5_timeout_cnt", 0); pop_check(32'(bus_if.timeout_cnt));

    // Scenario 6: soft restart from RUN keeps the status counters
    bus_if.soft_reset_req = 1'b1;
    step(1);
    bus_if.soft_reset_req = 1'b0;
    push("t6_sys_reset", 1); pop_check(32'(bus_if.sys_reset));
    n = 0;
    while (bus_if.pll_rst === 1'b1 && n < BUDGET) begin
      step(1);
      n++;
    end
    push("t6_pll_rst_width", RST_PULSE); pop_check(32'(n));
    push("t6_relock_cnt", 2);            pop_check(32'(bus_if.relock_cnt));
    push("t6_timeout_cnt", 0);           pop_check(32'(bus_if.timeout_cnt));

    // Asynchronous reset in the middle of PLL_RST
    bus_if.soft_reset_req = 1'b1;
    step(1);
    bus_if.soft_reset_req = 1'b0;
    step(2);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");

    // Scenario 3: no lock at all; repeated timeouts and saturation
    bus_if.locked = 1'b0;
    step(1);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      pll_rst_period(n);
      push("t3_period", RST_PULSE + LOCK_TIMEOUT); pop_check(32'(n));
      push("t3_timeout_cnt", k);                    pop_check(32'(bus_if.timeout_cnt));
    end
    bad = 0;
    for (int k = 4; k <= 300; k++) begin
      pll_rst_period(n);
      if (n < 0) begin
        bad++;
        break;
      end
    end
    push("t3_saturation_run_stalls", 0); pop_check(32'(bad));
    push("t3_timeout_sat", 255);         pop_check(32'(bus_if.timeout_cnt));
    pll_rst_period(n);
    push("t3_period_after_sat", RST_PULSE + LOCK_TIMEOUT); pop_check(32'(n));
    push("t3_timeout_hold", 255);        pop_check(32'(bus_if.timeout_cnt));
    push("t3_relock_cnt", 0);            pop_check(32'(bus_if.relock_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sits directly downstream of the system PLL wrapper, in the 50 MHz reference-clock domain.
- Drives the PLL's active-high rst input and consumes its asynchronous locked output.
- Produces a qualified core reset and a ready flag once lock has been stable for a programmable time.
- Automatically re-resets the PLL on lock timeout; counts timeouts and lock losses for OSD/debug status.

Parameters:
RST_PULSE, 16, cycles pll_rst is held high per PLL reset attempt (>=1)
LOCK_TIMEOUT, 1048576, cycles to wait for lock before re-resetting the PLL (~21 ms at 50 MHz, >=2)
STABLE_CYCLES, 1024, cycles locked must stay high before the core is released (>=1)
CNT_W, 24, width of the shared cycle counter; must hold max(RST_PULSE, LOCK_TIMEOUT, STABLE_CYCLES)-1

Ports:
refclk  input  1  reference clock, same clock that feeds the PLL
rst_n  input  1  asynchronous active-low reset
locked  input  1  PLL lock, asynchronous to refclk
soft_reset_req  input  1  synchronous request to restart the whole PLL sequence
pll_rst  output  1  active-high reset to the PLL
sys_reset  output  1  active-high core reset; low only in RUN
ready  output  1  high only in RUN
timeout_cnt  output  8  saturating count of lock timeouts
relock_cnt  output  8  saturating count of lock losses while in RUN

Behaviour:
- Clock and reset: one clock (refclk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=PLL_RST, cycle counter=0, both sync flops=0.
  - pll_rst=1, sys_reset=1, ready=0, timeout_cnt=0, relock_cnt=0.
- Lock synchroniser: locked passes through 2 refclk flops to give locked_s. Only locked_s is used internally.
- State register: one-hot, states PLL_RST, WAIT_LOCK, STABLE, RUN.
  - pll_rst = PLL_RST flop.
  - ready = RUN flop.
  - sys_reset = ~RUN flop.
  - All outputs change on the same edge the state changes; no combinational output paths.
- Counter: cleared on every state transition. Increments by 1 each cycle in PLL_RST, WAIT_LOCK and STABLE. Held at 0 in RUN.
- Priority within a cycle: soft_reset_req > lock loss > counter expiry.
- PLL_RST:
  - Counter reaching RST_PULSE-1 -> WAIT_LOCK.
  - pll_rst is therefore high for exactly RST_PULSE cycles.
- WAIT_LOCK:
  - locked_s=1 -> STABLE.
  - Otherwise, counter reaching LOCK_TIMEOUT-1 -> PLL_RST, and timeout_cnt increments (saturates at 255).
- STABLE:
  - locked_s=0 -> WAIT_LOCK; no counter increment, the timeout window restarts.
  - Counter reaching STABLE_CYCLES-1 with locked_s=1 -> RUN.
- RUN:
  - locked_s=0 -> WAIT_LOCK, and relock_cnt increments (saturates at 255).
  - sys_reset rises on that same edge.
- soft_reset_req:
  - In any state -> PLL_RST with counter cleared.
  - Held high, it keeps the block in PLL_RST (counter restarts every cycle).
  - Does not clear timeout_cnt or relock_cnt; only rst_n clears them.
- Latency: from locked_s first sampled high in WAIT_LOCK, ready rises STABLE_CYCLES+1 edges later. locked pin to locked_s adds 2 edges.
- Lock drop of 1 cycle in STABLE or RUN is honoured; there is no glitch filtering beyond the synchroniser.
- rst_n asserted mid-sequence: immediately returns all outputs to reset values, asynchronously.
- Counter saturation: timeout_cnt and relock_cnt stop at 8'hFF and never wrap.

Test Plan:
Use RST_PULSE=4, LOCK_TIMEOUT=64, STABLE_CYCLES=16 for all scenarios.
1. Release rst_n, locked=0 -> pll_rst=1 for exactly 4 cycles, then 0; sys_reset=1, ready=0 throughout.
2. Drive locked=1 at cycle 10 after reset release and hold it -> ready=1 and sys_reset=0 exactly 2+17 edges later; pll_rst stays 0.
3. Hold locked=0 -> pll_rst re-pulses (4 cycles) every 68 cycles; timeout_cnt reads 1,2,3... Run 300 timeouts -> timeout_cnt stays at 255.
4. In RUN, drop locked for 1 cycle -> sys_reset=1 and ready=0 3 edges after the drop; relock_cnt=1; ready returns 17 edges after locked_s is high again.
5. Toggle locked low at counter=10 in STABLE -> returns to WAIT_LOCK, no count increments, full 16-cycle stable wait restarts.
6. Pulse soft_reset_req in RUN with relock_cnt=2 -> pll_rst=1 for 4 cycles, sys_reset=1, counters unchanged. Assert rst_n low mid-PLL_RST -> all outputs at reset values, counters 0.
